// File: rtl/enabled_register_mux4to1_b32.sv
// Register-file leaf cells: a write-enabled storage register, a 32-bit 4:1 read
// selector, and a four-entry slice that wires one read port over four entries.

module enabledRegister #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   input  logic             CLK,
   input  logic             EN,
   input  logic             RST
);
   // A floating RST (four-port instantiation) evaluates false, leaving a plain enabled register.
   always_ff @(posedge CLK) begin
      if (RST)     Q <= '0;
      else if (EN) Q <= D;
   end
endmodule

module mux4to1B32 (
   input  logic        S1,
   input  logic        S0,
   input  logic [31:0] I3,
   input  logic [31:0] I2,
   input  logic [31:0] I1,
   input  logic [31:0] I0,
   output logic [31:0] Y
);
   // An unknown select matches no item, so Y goes X rather than picking a default input.
   always_comb begin
      Y = 'x;
      case ({S1, S0})
         2'b00:   Y = I0;
         2'b01:   Y = I1;
         2'b10:   Y = I2;
         2'b11:   Y = I3;
         default: Y = 'x;
      endcase
   end
endmodule

module enabled_register_mux4to1_b32 #(
   parameter int NUM_ENT = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NUM_ENT-1:0]         we,
   input  logic [31:0]                wd,
   input  logic [1:0]                 sel,
   output logic [31:0]                rd,
   output logic [NUM_ENT-1:0][31:0]   q
);
   for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
      enabledRegister #(.WIDTH(32)) u_ent (
         .D   (wd),
         .Q   (q[i]),
         .CLK (CLK),
         .EN  (we[i]),
         .RST (RST)
      );
   end

   // No write-to-read bypass: the port shows the new value only after the edge.
   mux4to1B32 u_rd_mux (
      .S1 (sel[1]),
      .S0 (sel[0]),
      .I3 (q[3]),
      .I2 (q[2]),
      .I1 (q[1]),
      .I0 (q[0]),
      .Y  (rd)
   );
endmodule

// File: tb/tb_enabled_register_mux4to1_b32.sv
// Randomized bench for the register slice and its read mux, checked against an
// array model of the four entries plus directed boundary cases.

module tb_enabled_register_mux4to1_b32;
   logic             CLK;
   logic             RST;
   logic [3:0]       we;
   logic [31:0]      wd;
   logic [1:0]       sel;
   logic [31:0]      rd;
   logic [3:0][31:0] q;

   logic        m_s1, m_s0;
   logic [31:0] m_i0, m_i1, m_i2, m_i3, m_y;

   logic [31:0] mem [4];
   int n_cmp = 0;
   int n_err = 0;

   enabled_register_mux4to1_b32 dut (
      .CLK (CLK), .RST (RST), .we (we), .wd (wd), .sel (sel), .rd (rd), .q (q)
   );

   mux4to1B32 u_mux (
      .S1 (m_s1), .S0 (m_s0), .I3 (m_i3), .I2 (m_i2), .I1 (m_i1), .I0 (m_i0), .Y (m_y)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time limit hit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   // One rising edge; the model applies the same edge semantics to the array.
   task automatic step();
      @(posedge CLK);
      if (RST) begin
         for (int i = 0; i < 4; i++) mem[i] = 32'h0;
      end else begin
         for (int i = 0; i < 4; i++) if (we[i]) mem[i] = wd;
      end
      #1;
   endtask

   task automatic chk_all(input string tag);
      for (int i = 0; i < 4; i++) chk(tag, q[i], mem[i]);
      chk({tag, "_rd"}, rd, mem[sel]);
   endtask

   initial begin
      RST = 1'b0; we = '0; wd = '0; sel = '0;
      m_s1 = 1'b0; m_s0 = 1'b0; m_i0 = '0; m_i1 = '0; m_i2 = '0; m_i3 = '0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;
      @(negedge CLK);

      // Reset wins over enable
      RST = 1'b1; we = 4'hF; wd = 32'hDEADBEEF;
      step();
      chk_all("reset");
      chk("reset_q0", q[0], 32'h0);
      RST = 1'b0; we = 4'h0;
      step();
      chk("post_reset_hold", q[0], 32'h0);

      // Write then hold with junk on D
      we = 4'b0001; wd = 32'h12345678;
      step();
      chk("write", q[0], 32'h12345678);
      we = 4'h0; wd = 32'hFFFFFFFF;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold", q[0], 32'h12345678);
      end

      // Back-to-back writes
      we = 4'b0100;
      for (int k = 1; k <= 3; k++) begin
         wd = k;
         step();
         chk("b2b", q[2], k);
      end
      we = 4'h0;

      // Read-after-write through the mux, no bypass
      sel = 2'b01; wd = 32'h5; we = 4'b0010;
      #1;
      chk("raw_before", rd, 32'h0);
      step();
      chk("raw_after", rd, 32'h5);
      we = 4'h0;

      // Standalone mux: select sweep with no clock involvement
      m_i0 = 32'hA0A0A0A0; m_i1 = 32'hB1B1B1B1; m_i2 = 32'hC2C2C2C2; m_i3 = 32'hD3D3D3D3;
      for (int s = 0; s < 4; s++) begin
         logic [31:0] pat [4];
         pat[0] = 32'hA0A0A0A0; pat[1] = 32'hB1B1B1B1; pat[2] = 32'hC2C2C2C2; pat[3] = 32'hD3D3D3D3;
         {m_s1, m_s0} = s[1:0];
         #1;
         chk("mux_sweep", m_y, pat[s]);
      end

      // Data tracking on S1S0=10; other inputs must not leak through
      {m_s1, m_s0} = 2'b10; m_i2 = 32'h0;
      #1;
      chk("mux_track0", m_y, 32'h0);
      m_i2 = 32'hFFFFFFFF;
      #1;
      chk("mux_track1", m_y, 32'hFFFFFFFF);
      m_i0 = 32'h11111111; m_i1 = 32'h22222222; m_i3 = 32'h33333333;
      #1;
      chk("mux_isolate", m_y, 32'hFFFFFFFF);

      // Random mux vectors
      for (int k = 0; k < 40; k++) begin
         logic [31:0] v [4];
         logic [1:0]  s;
         for (int i = 0; i < 4; i++) v[i] = $urandom;
         s = 2'($urandom_range(0, 3));
         m_i0 = v[0]; m_i1 = v[1]; m_i2 = v[2]; m_i3 = v[3];
         {m_s1, m_s0} = s;
         #1;
         chk("mux_rand", m_y, v[s]);
      end

      // Random register-file traffic with occasional mid-sequence resets
      @(negedge CLK);
      for (int k = 0; k < 300; k++) begin
         RST = ($urandom_range(0, 15) == 0);
         we  = 4'($urandom);
         wd  = $urandom;
         sel = 2'($urandom_range(0, 3));
         #1;
         chk("rand_pre", rd, mem[sel]);
         step();
         chk_all("rand");
         @(negedge CLK);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
